fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//   Shares the single-port VGA frame-buffer RAM between the vga_controller pixel reader and the processor's pixel writes.
//   VGA reads have absolute priority. Processor writes are buffered in a small FIFO and drained on idle port cycles.
//   A hardware clear engine can sweep the whole buffer with one colour index.
//   Sits between the processor, vga_controller and the frame-buffer RAM in skeleton.
// PARAMETERS
//   ADDR_W       19       frame-buffer address width
//   DATA_W       8        colour-index width
//   FIFO_DEPTH   4        processor write FIFO entries (power of 2)
//   PIXEL_COUNT  307200   valid addresses 0..PIXEL_COUNT-1 (640x480)
// PORTS
//   clock        in   1       system clock
//   resetn       in   1       asynchronous active-low reset
//   vga_rd_req   in   1       VGA wants the pixel at vga_rd_addr this cycle
//   vga_rd_addr  in   ADDR_W  VGA read address
//   vga_rd_data  out  DATA_W  read data (= ram_rdata, combinational)
//   vga_rd_valid out  1       vga_rd_data is valid for the request made 2 cycles earlier
//   cpu_wr_req   in   1       processor pixel write request
//   cpu_wr_addr  in   ADDR_W  processor write address
//   cpu_wr_data  in   DATA_W  processor write colour index
//   cpu_wr_ready out  1       FIFO can accept; write taken when req && ready
//   clear_req    in   1       1-cycle pulse: start a full-buffer clear
//   clear_color  in   DATA_W  colour used by the clear, sampled with clear_req
//   busy         out  1       clear in progress
//   clear_done   out  1       1-cycle pulse when the last clear write is issued
//   addr_err     out  1       1-cycle pulse: processor write dropped (address out of range)
//   fifo_level   out  3       FIFO occupancy, 0..FIFO_DEPTH
//   ram_addr     out  ADDR_W  registered RAM address
//   ram_wdata    out  DATA_W  registered RAM write data
//   ram_we       out  1       registered RAM write enable
//   ram_rdata    in   DATA_W  RAM read data, 1-cycle latency after ram_addr
// BEHAVIOUR
//   - Reset: all outputs 0, FIFO emptied, state IDLE. Reset is asynchronous.
//   - Reset asserted mid-clear or with queued writes discards all pending work.
//   - Per-cycle port grant (priority order): (1) vga_rd_req, (2) clear write if state CLEAR, (3) FIFO head write if state IDLE.
//   - Grants are registered onto ram_*. Only one grant per cycle.
//   - A cycle with no grant drives ram_we=0 and holds ram_addr.
//   - VGA read latency: req at cycle N -> ram_addr at N+1 -> vga_rd_valid=1 at N+2.
//   - Back-to-back VGA reads are fully pipelined.
//   - FIFO push:
//     - cpu_wr_ready = (fifo_level != FIFO_DEPTH); it does not consider a same-cycle pop.
//     - An accepted write with cpu_wr_addr >= PIXEL_COUNT is not pushed; addr_err pulses next cycle.
//   - FIFO pop occurs only on a cycle granted to the FIFO.
//   - Writes drain in arrival order. Push and pop in the same cycle leave the level unchanged.
//   - FSM IDLE -> CLEAR on clear_req:
//     - clr_addr<=0; colour latched; busy=1 the next cycle.
//     - clear_req while busy is ignored.
//   - CLEAR: each granted cycle writes colour to clr_addr, then clr_addr++.
//     - The write to PIXEL_COUNT-1 pulses clear_done, and the FSM returns to IDLE next cycle.
//   - The FIFO keeps accepting during CLEAR but does not drain until IDLE.
//     - Queued writes therefore land on top of the cleared image.
//   - Address counters never wrap past PIXEL_COUNT-1. Width arithmetic is unsigned ADDR_W.
// TESTING
//   1. Reset, vga_rd_req=1 with addr 0,1,2 on consecutive cycles, RAM model returns addr[7:0] -> vga_rd_valid high from cycle 3, data 0,1,2.
//   2. Idle VGA, processor writes (5,0xAA),(6,0xBB) -> ram_we=1 with addr 5 then 6 on consecutive cycles, fifo_level returns to 0.
//   3. vga_rd_req held high, 5 processor writes -> 4 accepted, cpu_wr_ready=0 on the 5th, no ram_we; drop vga_rd_req -> 4 writes in order.
//   4. cpu_wr_addr=307200 -> addr_err pulse, fifo_level stays 0, no RAM write.
//   5. clear_req colour 0x03 with VGA reads every 2nd cycle -> every address 0..307199 written 0x03 exactly once, clear_done pulses once.
//   6. Assert resetn=0 at clr_addr=1000 with 2 writes queued -> busy=0, fifo_level=0, ram_we=0 immediately, no further writes.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA reads pre-empt everything, the clear engine
// sweeps the buffer, and buffered processor writes fill the remaining idle cycles.
//
// state   | meaning
// S_IDLE  | FIFO head may drain on cycles VGA leaves free
// S_CLEAR | clear engine owns the free cycles; FIFO only accumulates
module fb_port_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PIXEL_COUNT = 307200,
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  output logic              busy,
  output logic              clear_done,
  output logic              addr_err,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_COUNT - 1);
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;

  logic grant_vga, grant_clr, grant_fifo, clr_last;
  logic rd_pend_q;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              wr_accept, wr_in_range, push, pop;

  assign vga_rd_data  = ram_rdata;
  assign busy         = (state_q == S_CLEAR);
  assign fifo_level   = level_q;
  assign cpu_wr_ready = (level_q != DEPTH_LVL);

  assign wr_accept   = cpu_wr_req & cpu_wr_ready;
  assign wr_in_range = (cpu_wr_addr <= LAST_ADDR);
  assign push        = wr_accept & wr_in_range;
  assign pop         = grant_fifo;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    grant_vga   = vga_rd_req;
    grant_clr   = 1'b0;
    grant_fifo  = 1'b0;
    clr_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!vga_rd_req && (level_q != '0)) grant_fifo = 1'b1;
        if (clear_req) begin
          state_d     = S_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
        end
      end
      S_CLEAR: begin
        if (!vga_rd_req) begin
          grant_clr = 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            clr_last = 1'b1;
            state_d  = S_IDLE;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
    end
  end

  // One grant per cycle lands on the RAM port; an ungranted cycle holds the address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_we       <= 1'b0;
      rd_pend_q    <= 1'b0;
      vga_rd_valid <= 1'b0;
      clear_done   <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      ram_we       <= grant_clr | grant_fifo;
      rd_pend_q    <= grant_vga;
      vga_rd_valid <= rd_pend_q;
      clear_done   <= clr_last;
      addr_err     <= wr_accept & ~wr_in_range;
      if (grant_vga) begin
        ram_addr <= vga_rd_addr;
      end else if (grant_clr) begin
        ram_addr  <= clr_addr_q;
        ram_wdata <= clr_color_q;
      end else if (grant_fifo) begin
        ram_addr  <= fifo_addr[rd_ptr_q];
        ram_wdata <= fifo_data[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= cpu_wr_addr;
      fifo_data[wr_ptr_q] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed and random traffic against a queue-based
// reference, plus full clear sweep and reset-during-clear scenarios.
module tb_fb_port_arbiter;

  localparam int PC    = 2048;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        vga_rd_req;
  logic [18:0] vga_rd_addr;
  logic [7:0]  vga_rd_data;
  logic        vga_rd_valid;
  logic        cpu_wr_req;
  logic [18:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ready;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        busy;
  logic        clear_done;
  logic        addr_err;
  logic [2:0]  fifo_level;
  logic [18:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = 8'h00;

  fb_port_arbiter #(
    .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(DEPTH), .PIXEL_COUNT(PC)
  ) dut (
    .clock(clock), .resetn(resetn),
    .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
    .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done), .addr_err(addr_err),
    .fifo_level(fifo_level),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // RAM model: read data is the low address byte, one cycle after the address.
  always @(posedge clock) ram_rdata <= ram_addr[7:0];

  int   n_checks = 0;
  int   n_err    = 0;
  logic log_en   = 1'b0;
  int   done_cnt = 0;
  wr_t  wlog[$];

  always @(negedge clock) begin
    if (log_en && ram_we) wlog.push_back({ram_addr, ram_wdata});
    if (log_en && clear_done) done_cnt++;
  end

  // Reference: pending writes in arrival order, the RAM port value, read pipeline.
  wr_t         mq[$];
  logic [18:0] m_addr;
  logic [7:0]  m_wdata;
  logic        p_v;
  logic [18:0] p_a;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic vr, input logic [18:0] va, input logic cw,
                     input logic [18:0] ca, input logic [7:0] cd);
    logic        e_we, e_err, e_ready, ev;
    logic [18:0] ea;
    wr_t         w;
    vga_rd_req  = vr;
    vga_rd_addr = va;
    cpu_wr_req  = cw;
    cpu_wr_addr = ca;
    cpu_wr_data = cd;
    #1;
    e_ready = (mq.size() != DEPTH);
    chk("ready", cpu_wr_ready, e_ready);
    e_we  = 1'b0;
    e_err = 1'b0;
    if (vr) begin
      m_addr = va;
    end else if (mq.size() > 0) begin
      w       = mq.pop_front();
      e_we    = 1'b1;
      m_addr  = w.a;
      m_wdata = w.d;
    end
    if (cw && e_ready) begin
      if (ca < 19'(PC)) mq.push_back({ca, cd});
      else e_err = 1'b1;
    end
    ev  = p_v;
    ea  = p_a;
    p_v = vr;
    p_a = va;
    tick();
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, m_addr);
    if (e_we) chk("ram_wdata", ram_wdata, m_wdata);
    chk("addr_err", addr_err, e_err);
    chk("fifo_level", fifo_level, mq.size());
    chk("rd_valid", vga_rd_valid, ev);
    if (ev) chk("rd_data", vga_rd_data, ea[7:0]);
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int   bad;
    logic hit;
    resetn      = 1'b0;
    vga_rd_req  = 1'b0;
    vga_rd_addr = '0;
    cpu_wr_req  = 1'b0;
    cpu_wr_addr = '0;
    cpu_wr_data = '0;
    clear_req   = 1'b0;
    clear_color = '0;
    m_addr  = '0;
    m_wdata = '0;
    p_v     = 1'b0;
    p_a     = '0;
    tick();
    tick();
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 19'd0);
    chk("rst_ram_wdata", ram_wdata, 8'd0);
    chk("rst_valid", vga_rd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", clear_done, 1'b0);
    chk("rst_err", addr_err, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    resetn = 1'b1;
    tick();

    // pipelined VGA reads 0,1,2
    for (int i = 0; i < 3; i++) cyc(1'b1, 19'(i), 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, '0);

    // two processor writes on an idle port
    cyc(1'b0, '0, 1'b1, 19'd5, 8'hAA);
    cyc(1'b0, '0, 1'b1, 19'd6, 8'hBB);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, '0);

    // FIFO fills behind continuous reads, then drains in order
    for (int i = 0; i < 5; i++) cyc(1'b1, 19'(40 + i), 1'b1, 19'(100 + i), 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0, '0, '0);

    // out-of-range write is dropped
    cyc(1'b0, '0, 1'b1, 19'(PC), 8'h5A);
    cyc(1'b0, '0, 1'b0, '0, '0);
    cyc(1'b0, '0, 1'b1, 19'(PC - 1), 8'hC3);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, '0);

    // random mixed traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) == 0, 19'($urandom_range(0, PC - 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? 19'(PC + $urandom_range(0, 50))
                                      : 19'($urandom_range(0, PC - 1)),
          8'($urandom));
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, '0, '0);

    // full clear with VGA reads every other cycle and writes queued mid-clear
    wlog.delete();
    done_cnt    = 0;
    log_en      = 1'b1;
    clear_color = 8'h03;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    clear_color = 8'h00;
    chk("clr_busy_start", busy, 1'b1);
    for (int i = 0; i < 10000 && busy; i++) begin
      vga_rd_req  = (i % 2 == 0);
      vga_rd_addr = 19'($urandom_range(0, PC - 1));
      cpu_wr_req  = (i == 100 || i == 101);
      cpu_wr_addr = (i == 100) ? 19'd10 : 19'd20;
      cpu_wr_data = 8'h77;
      clear_req   = (i == 50);
      clear_color = (i == 50) ? 8'h55 : 8'h00;
      tick();
      if (i == 110) chk("clr_fifo_hold", fifo_level, 3'd2);
    end
    vga_rd_req = 1'b0;
    cpu_wr_req = 1'b0;
    clear_req  = 1'b0;
    chk("clr_finished", busy, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    log_en = 1'b0;
    chk("clr_done_count", done_cnt, 1);
    chk("clr_write_count", wlog.size(), PC + 2);
    bad = 0;
    for (int i = 0; i < wlog.size() && i < PC; i++)
      if (wlog[i].a != 19'(i) || wlog[i].d != 8'h03) bad++;
    chk("clr_sweep_bad", bad, 0);
    if (wlog.size() == PC + 2) begin
      chk("clr_tail0", wlog[PC], {19'd10, 8'h77});
      chk("clr_tail1", wlog[PC + 1], {19'd20, 8'h77});
    end
    chk("clr_level_end", fifo_level, 3'd0);

    // reset in the middle of a clear with writes queued
    wlog.delete();
    log_en      = 1'b1;
    clear_color = 8'h03;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 19'd30;
    cpu_wr_data = 8'h11;
    tick();
    cpu_wr_addr = 19'd31;
    tick();
    cpu_wr_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      if (ram_we && ram_addr == 19'd999) hit = 1'b1;
    end
    chk("rst_reached_1000", hit, 1'b1);
    chk("rst_pre_level", fifo_level, 3'd2);
    chk("rst_pre_busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_level", fifo_level, 3'd0);
    chk("rst_mid_we", ram_we, 1'b0);
    chk("rst_mid_addr", ram_addr, 19'd0);
    tick();
    tick();
    resetn = 1'b1;
    wlog.delete();
    for (int i = 0; i < 30; i++) tick();
    log_en = 1'b0;
    chk("rst_no_writes", wlog.size(), 0);
    chk("rst_post_busy", busy, 1'b0);
    chk("rst_post_level", fifo_level, 3'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
